key_event_fsm: RTL and testbench

- Downstream consumer of the switch debouncer: takes the debounced level `db` and the debouncer's periodic `m_tick` strobe.
- Converts them into one-cycle key events: press, release, long-press and auto-repeat.
- Also provides a held-level flag and a wrap-around press counter.
- Feeds menu/counter logic that must not see raw levels.

---
 rtl/key_event_fsm.sv | 124 ++++++++++++
 tb/tb_key_event_fsm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/key_event_fsm.sv
// key_event_fsm
//   Turns the debounced key level into one-cycle key events (press, release,
//   long-press, auto-repeat). It also provides a held-level flag and a
//   wrap-around press counter. Timing of long-press and repeat is measured in
//   m_tick periods, not clk cycles.
//
// Ports
//   clk          in   system clock, all logic on rising edge
//   reset        in   synchronous active-high reset
//   db           in   debounced key level, 1 = pressed
//   m_tick       in   one-clk timebase strobe
//   press        out  one-cycle pulse on key press
//   release_p    out  one-cycle pulse on key release ("release" is a reserved word)
//   long_press   out  one-cycle pulse when hold reaches LONG_TICKS
//   repeat_p     out  one-cycle auto-repeat pulse
//   was_long     out  with release_p: 1 if that hold reached long_press
//   held         out  1 while the FSM is not in IDLE
//   press_count  out  presses since reset, modulo 2^PCW
module key_event_fsm #(
  parameter int CW           = 8,
  parameter int LONG_TICKS   = 24,
  parameter int REPEAT_TICKS = 6,
  parameter int PCW          = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           db,
  input  logic           m_tick,
  output logic           press,
  output logic           release_p,
  output logic           long_press,
  output logic           repeat_p,
  output logic           was_long,
  output logic           held,
  output logic [PCW-1:0] press_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      press_count <= '0;
      press       <= 1'b0;
      release_p   <= 1'b0;
      long_press  <= 1'b0;
      repeat_p    <= 1'b0;
      was_long    <= 1'b0;
      held        <= 1'b0;
    end else begin
      // Pulses default low so every event lasts exactly one clk.
      press      <= 1'b0;
      release_p  <= 1'b0;
      long_press <= 1'b0;
      repeat_p   <= 1'b0;
      was_long   <= 1'b0;
      held       <= 1'b0;
      case (state)
        IDLE: begin
          // m_tick is deliberately ignored here. A tick on the leaving edge is not counted.
          if (db) begin
            state       <= PRESSED;
            press       <= 1'b1;
            held        <= 1'b1;
            cnt         <= '0;
            press_count <= press_count + 1'b1;
          end
        end
        PRESSED: begin
          // Release wins over a coincident tick.
          if (!db) begin
            state     <= IDLE;
            release_p <= 1'b1;
          end else begin
            held <= 1'b1;
            if (m_tick) begin
              if (cnt == LONG_LAST) begin
                state      <= REPEAT;
                long_press <= 1'b1;
                cnt        <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end
        REPEAT: begin
          if (!db) begin
            state     <= IDLE;
            release_p <= 1'b1;
            was_long  <= 1'b1;
          end else begin
            held <= 1'b1;
            if (m_tick) begin
              if (cnt == REPEAT_LAST) begin
                repeat_p <= 1'b1;
                cnt      <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          // Illegal encoding: recover to IDLE silently.
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_fsm.sv
module tb_key_event_fsm;

  localparam int L = 3;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       db = 1'b0;
  logic       m_tick = 1'b0;
  logic       press, release_p, long_press, repeat_p, was_long, held;
  logic [7:0] press_count;

  key_event_fsm #(.CW(8), .LONG_TICKS(L), .REPEAT_TICKS(R), .PCW(8)) dut (
    .clk(clk), .reset(reset), .db(db), .m_tick(m_tick),
    .press(press), .release_p(release_p), .long_press(long_press),
    .repeat_p(repeat_p), .was_long(was_long), .held(held),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pr;
    logic       rl;
    logic       lp;
    logic       rp;
    logic       wl;
    logic       hd;
    logic [7:0] pc;
  } out_t;

  out_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int phase = 0;
  logic last_tick = 1'b0;

  // Reference model state.
  int m_state = 0;  // 0 idle, 1 pressed, 2 repeat
  int m_cnt = 0;
  logic [7:0] m_pc = 8'd0;

  // Observed event tallies, for directed per-scenario checks.
  int n_press, n_rel, n_long, n_rep;
  logic rel_wl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; rel_wl = 1'b0;
  endtask

  task automatic step(input logic db_v, input logic rst_v);
    out_t e, o;
    @(negedge clk);
    db     = db_v;
    reset  = rst_v;
    m_tick = (phase == 3);
    last_tick = m_tick;
    phase  = (phase + 1) % 4;
    // Expected outputs after the coming edge.
    e = '0;
    if (rst_v) begin
      m_state = 0; m_cnt = 0; m_pc = 8'd0;
    end else begin
      case (m_state)
        0: if (db_v) begin
             m_state = 1; m_cnt = 0; m_pc = m_pc + 8'd1; e.pr = 1'b1;
           end
        1: if (!db_v) begin
             m_state = 0; e.rl = 1'b1;
           end else if (m_tick) begin
             if (m_cnt == L - 1) begin m_state = 2; m_cnt = 0; e.lp = 1'b1; end
             else m_cnt++;
           end
        default: if (!db_v) begin
             m_state = 0; e.rl = 1'b1; e.wl = 1'b1;
           end else if (m_tick) begin
             if (m_cnt == R - 1) begin m_cnt = 0; e.rp = 1'b1; end
             else m_cnt++;
           end
      endcase
    end
    e.hd = (m_state != 0);
    e.pc = m_pc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = '{press, release_p, long_press, repeat_p, was_long, held, press_count};
    e = sb.pop_front();
    chk("press",       32'(o.pr), 32'(e.pr));
    chk("release",     32'(o.rl), 32'(e.rl));
    chk("long_press",  32'(o.lp), 32'(e.lp));
    chk("repeat_p",    32'(o.rp), 32'(e.rp));
    chk("was_long",    32'(o.wl), 32'(e.wl));
    chk("held",        32'(o.hd), 32'(e.hd));
    chk("press_count", 32'(o.pc), 32'(e.pc));
    if (o.pr === 1'b1) n_press++;
    if (o.rl === 1'b1) begin n_rel++; rel_wl = o.wl; end
    if (o.lp === 1'b1) n_long++;
    if (o.rp === 1'b1) n_rep++;
  endtask

  // Hold db high until n m_tick strobes have been sampled.
  task automatic hold_ticks(input int n);
    int k = 0;
    while (k < n) begin
      step(1'b1, 1'b0);
      if (last_tick) k++;
    end
  endtask

  initial begin
    // Reset, then idle with db low.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    chk("idle_press_count", 32'(press_count), 32'd0);

    // Short press: two ticks, then release.
    clear_counts();
    step(1'b1, 1'b0);
    hold_ticks(2);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("s1_n_press", n_press, 1);
    chk("s1_n_rel",   n_rel,   1);
    chk("s1_n_long",  n_long,  0);
    chk("s1_was_long", 32'(rel_wl), 32'd0);
    chk("s1_count",   32'(press_count), 32'd1);

    // Long hold: long_press on tick 3, repeats on ticks 5 and 7.
    clear_counts();
    step(1'b1, 1'b0);
    hold_ticks(7);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("s2_n_long",  n_long, 1);
    chk("s2_n_rep",   n_rep,  2);
    chk("s2_n_rel",   n_rel,  1);
    chk("s2_was_long", 32'(rel_wl), 32'd1);

    // Release coincides with the third tick: release only.
    clear_counts();
    step(1'b1, 1'b0);
    hold_ticks(2);
    while (phase != 3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("s3_n_long",  n_long, 0);
    chk("s3_n_rel",   n_rel,  1);
    chk("s3_was_long", 32'(rel_wl), 32'd0);

    // 257 short presses wrap the 8-bit counter to 1.
    step(1'b0, 1'b1);
    clear_counts();
    for (int i = 0; i < 257; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    chk("s4_n_press", n_press, 257);
    chk("s4_count",   32'(press_count), 32'd1);

    // Reset mid-REPEAT with db held: no release, new press right after.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    hold_ticks(5);
    chk("s5_in_repeat_held", 32'(held), 32'd1);
    clear_counts();
    step(1'b1, 1'b1);
    chk("s5_n_rel",   n_rel, 0);
    chk("s5_count_rst", 32'(press_count), 32'd0);
    step(1'b1, 1'b0);
    chk("s5_n_press", n_press, 1);
    chk("s5_count",   32'(press_count), 32'd1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
